// File: rtl/interp_line_ctrl.sv
// Line scheduler for the 8-tap fractional interpolation bank: buffers input samples into a
// border-replicated 8-sample window, drives it to the external bank and normalises the returned sum.
module interp_line_ctrl #(
    parameter int SAMPLE_W = 10,
    parameter int SUM_W    = 32,
    parameter int SHIFT    = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cfg_start_i,
    input  logic [3:0]            cfg_frac_i,
    input  logic [7:0]            cfg_len_i,
    output logic                  busy_o,
    output logic                  done_o,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [SAMPLE_W-1:0]   s_data_i,
    output logic [8*SUM_W-1:0]    tap_x_o,
    output logic [3:0]            tap_frac_o,
    input  logic [SUM_W-1:0]      bank_sum_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [SAMPLE_W-1:0]   m_data_o,
    output logic                  m_last_o
);

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    localparam logic [SUM_W-1:0]        ROUND = SUM_W'(2 ** (SHIFT - 1));
    localparam logic signed [SUM_W-1:0] MAX_S = {{(SUM_W - SAMPLE_W){1'b0}}, {SAMPLE_W{1'b1}}};

    state_t                stateQ, stateD;
    logic [3:0]            fracQ, fracD;
    logic [7:0]            lenQ, lenD;
    logic [7:0]            inCntQ, inCntD;
    logic [7:0]            outCntQ, outCntD;
    logic [SAMPLE_W-1:0]   winQ [8];
    logic [SAMPLE_W-1:0]   winD [8];
    logic                  mValidQ, mValidD;
    logic                  mLastQ, mLastD;
    logic [SAMPLE_W-1:0]   mDataQ, mDataD;
    logic                  doneQ, doneD;

    logic                  slotFree, sReady, load;
    logic [7:0]            primeTarget;
    logic [SUM_W-1:0]      rounded;
    logic signed [SUM_W-1:0] shifted;
    logic [SAMPLE_W-1:0]   result;

    // Phase 0 bypasses the bank; otherwise round-half-up, arithmetic shift, clip to sample range.
    always_comb begin
        rounded = bank_sum_i + ROUND;
        shifted = $signed(rounded) >>> SHIFT;
        if (fracQ == 4'd0) begin
            result = winQ[3];
        end else if (shifted[SUM_W-1]) begin
            result = '0;
        end else if (shifted > MAX_S) begin
            result = '1;
        end else begin
            result = shifted[SAMPLE_W-1:0];
        end
    end

    always_comb begin
        stateD      = stateQ;
        fracD       = fracQ;
        lenD        = lenQ;
        inCntD      = inCntQ;
        outCntD     = outCntQ;
        winD        = winQ;
        mValidD     = mValidQ;
        mLastD      = mLastQ;
        mDataD      = mDataQ;
        doneD       = 1'b0;
        sReady      = 1'b0;
        load        = 1'b0;
        slotFree    = !mValidQ || m_ready_i;
        primeTarget = (lenQ < 8'd5) ? lenQ : 8'd5;

        case (stateQ)
            IDLE: begin
                if (cfg_start_i) begin
                    fracD   = cfg_frac_i;
                    lenD    = (cfg_len_i == 8'd0) ? 8'd1 : cfg_len_i;
                    inCntD  = '0;
                    outCntD = '0;
                    stateD  = PRIME;
                end
            end
            PRIME: begin
                sReady = 1'b1;
                if (s_valid_i) begin
                    // First sample fills the whole window so the left border is replicated.
                    for (int i = 0; i < 8; i++) begin
                        if (inCntQ == 8'd0 || i >= int'(inCntQ) + 3) begin
                            winD[i] = s_data_i;
                        end
                    end
                    inCntD = inCntQ + 8'd1;
                    if (inCntQ + 8'd1 == primeTarget) begin
                        stateD = RUN;
                    end
                end
            end
            RUN: begin
                sReady = (inCntQ < lenQ) && slotFree;
                load   = (outCntQ < lenQ) && slotFree && ((inCntQ == lenQ) || s_valid_i);
                if (mValidQ && m_ready_i) begin
                    mValidD = 1'b0;
                    if (mLastQ) begin
                        mLastD = 1'b0;
                        doneD  = 1'b1;
                        stateD = IDLE;
                    end
                end
                if (load) begin
                    mDataD  = result;
                    mValidD = 1'b1;
                    mLastD  = (outCntQ == lenQ - 8'd1);
                    outCntD = outCntQ + 8'd1;
                    for (int i = 0; i < 7; i++) begin
                        winD[i] = winQ[i+1];
                    end
                    // Once the line is exhausted W[7] keeps the last sample (right border).
                    if (inCntQ < lenQ) begin
                        winD[7] = s_data_i;
                        inCntD  = inCntQ + 8'd1;
                    end
                end
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stateQ  <= IDLE;
            fracQ   <= '0;
            lenQ    <= '0;
            inCntQ  <= '0;
            outCntQ <= '0;
            mValidQ <= 1'b0;
            mLastQ  <= 1'b0;
            mDataQ  <= '0;
            doneQ   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                winQ[i] <= '0;
            end
        end else begin
            stateQ  <= stateD;
            fracQ   <= fracD;
            lenQ    <= lenD;
            inCntQ  <= inCntD;
            outCntQ <= outCntD;
            mValidQ <= mValidD;
            mLastQ  <= mLastD;
            mDataQ  <= mDataD;
            doneQ   <= doneD;
            winQ    <= winD;
        end
    end

    always_comb begin
        tap_x_o = '0;
        for (int i = 0; i < 8; i++) begin
            tap_x_o[i*SUM_W +: SUM_W] = SUM_W'(winQ[i]);
        end
    end

    assign tap_frac_o = fracQ;
    assign busy_o     = (stateQ != IDLE);
    assign done_o     = doneQ;
    assign s_ready_o  = sReady;
    assign m_valid_o  = mValidQ;
    assign m_data_o   = mDataQ;
    assign m_last_o   = mLastQ;

endmodule

// File: doc/interp_line_ctrl.md
Name: interp_line_ctrl

Overview:
- Line scheduler for the 8-tap, 1/16-precision fractional interpolation filter bank.
- The bank is the per-tap MCM blocks plus an adder tree, all combinational and external to this block.
- This block buffers an input sample stream into an 8-sample window with border replication and drives the window and fractional phase to the bank.
- It rounds, shifts and clips the returned sum, and emits one interpolated sample per output position under valid/ready flow control.

Parameters:
SAMPLE_W, 10, sample bit depth (unsigned samples)
SUM_W, 32, width of tap operands and bank sum
SHIFT, 6, normalisation shift (coefficients sum to 64)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
cfg_start  in  1  start-line pulse, honoured only in IDLE
cfg_frac  in  4  fractional phase 0..15, latched on start
cfg_len  in  8  outputs per line N, 1..255, latched on start (0 treated as 1)
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after last output accepted
s_valid  in  1  input sample valid
s_ready  out  1  input sample accepted when s_valid&&s_ready
s_data  in  SAMPLE_W  input sample
tap_x  out  8*SUM_W  window W[0..7], W[i] at bits [i*SUM_W +: SUM_W], zero-extended
tap_frac  out  4  latched phase to bank
bank_sum  in  SUM_W  signed bank result for current tap_x/tap_frac (combinational)
m_valid  out  1  output valid
m_ready  in  1  output accepted when m_valid&&m_ready
m_data  out  SAMPLE_W  interpolated sample
m_last  out  1  high with final output of line

Behaviour:
- Reset: state IDLE; busy, done, s_ready, m_valid, m_last = 0; m_data, tap_x, tap_frac = 0; counters cleared. Reset mid-line aborts the line; partial output is discarded.
- Output k uses input positions k-3..k+4, clamped to [0, N-1]. The line consumes exactly N inputs and produces exactly N outputs.
- FSM IDLE -> PRIME -> RUN -> IDLE.
  - IDLE: on cfg_start, latch frac and len, clear in_cnt and out_cnt, busy=1, go PRIME.
  - PRIME: s_ready=1. The accept with in_cnt=0 writes s_data to W[0..7]. An accept with in_cnt=j (1..4) writes s_data to W[3+j..7]. Go RUN when in_cnt reaches min(5,N). Result: W = {s0,s0,s0,s0,s1,...}, with the last sample replicated when N<5.
  - RUN: an output load occurs when out_cnt<N, slot free (!m_valid || m_ready), and (in_cnt==N || s_valid).
  - s_ready = (in_cnt<N) && slot free. This is combinational from m_ready.
  - On a load: m_data <= result; m_valid <= 1; m_last <= (out_cnt==N-1); out_cnt++.
  - Also on a load: window shifts W[i] <= W[i+1] for i in 0..6. W[7] <= s_data (in_cnt++) if in_cnt<N, else W[7] is held (replication).
  - When the m_last beat is accepted: m_valid=0, done=1 for one cycle, busy=0, go IDLE.
- Result computation:
  - cfg_frac==0: result = W[3] (bank bypassed).
  - Otherwise: t = (bank_sum + 2^(SHIFT-1)) >>> SHIFT, arithmetic on SUM_W bits; result = clip(t, 0, 2^SAMPLE_W-1).
- Latency: one output register stage. m_data for output k appears the cycle after its load condition.
- Backpressure: while m_valid && !m_ready, m_data, m_last, the window and counters hold; s_ready=0.
- Simultaneous accept and load in the same cycle is allowed; throughput is 1 sample/cycle.
- cfg_start while busy: ignored; latched config unchanged.
- tap_x and tap_frac are registered-state outputs, stable whenever no load occurs.

Test Plan:
- Reset -> all outputs 0, s_ready=0. Assert rst mid-line after 3 outputs -> next cycle IDLE, busy=0; a new start with N=8 runs cleanly.
- frac=0, N=8, inputs 10..17, m_ready=1 -> m_data 10..17 on consecutive cycles; m_last on 17; done pulse next cycle; 8 input accepts total.
- frac=3, N=3, inputs 1,2,3 -> tap_x for outputs 0,1,2 = {1,1,1,1,2,3,3,3}, {1,1,1,2,3,3,3,3}, {1,1,2,3,3,3,3,3}; only 3 inputs accepted.
- frac=8, bank model driven: bank_sum=95 -> 1; 32768 -> 512; -100 -> 0; 70000 -> 1023 (SAMPLE_W=10).
- N=16, hold m_ready low 5 cycles after output 4 -> m_data stable, s_ready=0, no input consumed. Release m_ready -> sequence resumes with no loss or duplication.
- cfg_start pulsed with frac=5, len=2 while busy -> ignored; the line completes with the original frac and len.
